// File: rtl/ram_req_ctrl_d0.sv
// Requester-side controller for a single-port synchronous-read RAM.
// Serves reads and byte-masked writes; partial writes run as read-modify-write.
module ram_req_ctrl_d0 #(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [AWIDTH-1:0]        req_addr,
    input  logic [DWIDTH-1:0]        req_wdata,
    input  logic [(DWIDTH/8)-1:0]    req_be,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DWIDTH-1:0]        rsp_rdata,
    output logic                     busy,
    output logic [AWIDTH-1:0]        ram_addr,
    output logic [DWIDTH-1:0]        ram_din,
    output logic                     ram_we,
    input  logic [DWIDTH-1:0]        ram_dout,
    output logic [1:0]               fsm_state
);
    localparam int NBYTES = DWIDTH / 8;

    // Handshakes: a request transfers on a rising edge with req_valid & req_ready;
    // a response transfers on a rising edge with rsp_valid & rsp_ready.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_WAIT   = 2'd1,
        RMW_MERGE = 2'd2,
        RSP       = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [AWIDTH-1:0]   addr_q;
    logic [DWIDTH-1:0]   wdata_q;
    logic [NBYTES-1:0]   be_q;
    logic                accept;
    logic                be_full;
    logic                be_null;

    assign accept  = req_valid & req_ready;
    assign be_full = &req_be;
    assign be_null = ~|req_be;
    assign fsm_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !req_we) begin
                    state_next = RD_WAIT;
                end else if (accept && req_we && !be_full && !be_null) begin
                    state_next = RMW_MERGE;
                end
            end
            RD_WAIT:   state_next = RSP;
            RMW_MERGE: state_next = IDLE;
            RSP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) & reset_n;
        busy      = (state != IDLE);
        ram_addr  = addr_q;
        ram_din   = req_wdata;
        ram_we    = 1'b0;
        case (state)
            IDLE: begin
                ram_addr = req_addr;
                ram_we   = accept & req_we & be_full;
            end
            RMW_MERGE: begin
                // RAM output already reflects addr_q, latched at the acceptance edge.
                for (int i = 0; i < NBYTES; i++) begin
                    ram_din[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : ram_dout[8*i +: 8];
                end
                ram_we = reset_n;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (state == IDLE && accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else if (state == RD_WAIT) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= ram_dout;
        end else if (state == RSP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ram_req_ctrl_d0.sv
// Directed bench for ram_req_ctrl_d0 with a behavioural synchronous-read RAM.
module tb_ram_req_ctrl_d0;
    localparam int AWIDTH = 3;
    localparam int DWIDTH = 32;
    localparam int NBYTES = DWIDTH / 8;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [AWIDTH-1:0] req_addr = '0;
    logic [DWIDTH-1:0] req_wdata = '0;
    logic [NBYTES-1:0] req_be = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              busy;
    logic [AWIDTH-1:0] ram_addr;
    logic [DWIDTH-1:0] ram_din;
    logic              ram_we;
    logic [DWIDTH-1:0] ram_dout;
    logic [1:0]        fsm_state;

    int checks = 0;
    int errors = 0;

    // RAM model with a preload port used only while the controller is idle
    logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];
    logic [AWIDTH-1:0] ram_addr_lat = '0;
    logic              pl_en = 1'b0;
    logic [AWIDTH-1:0] pl_addr = '0;
    logic [DWIDTH-1:0] pl_data = '0;

    always @(posedge clock) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_din;
        ram_addr_lat <= ram_addr;
    end
    assign ram_dout = mem[ram_addr_lat];

    always #5 clock = ~clock;

    ram_req_ctrl_d0 #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .ram_dout(ram_dout), .fsm_state(fsm_state)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic do_read(input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] exp, input string name);
        int n;
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = a;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL %s: rsp_valid timeout, got 0 expected 1", name);
        end else if (rsp_rdata !== exp) begin
            errors++;
            $display("FAIL %s: rsp_rdata got %h expected %h", name, rsp_rdata, exp);
        end
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_be = '1; req_addr = 3'd0; req_wdata = 32'hFFFF_FFFF;
        tick(); tick();
        checks++;
        if (ram_we !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
            rsp_rdata !== '0 || fsm_state !== 2'd0) begin
            errors++;
            $display("FAIL reset: we=%b rdy=%b vld=%b busy=%b rdata=%h st=%0d expected 0 0 0 0 0 0",
                     ram_we, req_ready, rsp_valid, busy, rsp_rdata, fsm_state);
        end
        req_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: req_ready got %b expected 1", req_ready);
        end
        tick();
    endtask

    task automatic test_read();
        preload(3'd3, 32'hDEAD_BEEF);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3;
        #1;
        checks++;
        if (req_ready !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 3'd3) begin
            errors++;
            $display("FAIL read_issue: rdy=%b we=%b addr=%0d expected 1 0 3", req_ready, ram_we, ram_addr);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0 || fsm_state !== 2'd1) begin
            errors++;
            $display("FAIL read_wait: vld=%b busy=%b rdy=%b st=%0d expected 0 1 0 1", rsp_valid, busy, req_ready, fsm_state);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL read_rsp: vld=%b rdata=%h expected 1 deadbeef", rsp_valid, rsp_rdata);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL read_done: vld=%b rdy=%b busy=%b expected 0 1 0", rsp_valid, req_ready, busy);
        end
    endtask

    task automatic test_full_write();
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 3'd5; req_wdata = 32'h1234_5678;
        #1;
        checks++;
        if (ram_we !== 1'b1 || req_ready !== 1'b1 || ram_din !== 32'h1234_5678 || ram_addr !== 3'd5) begin
            errors++;
            $display("FAIL full_write: we=%b rdy=%b din=%h addr=%0d expected 1 1 12345678 5", ram_we, req_ready, ram_din, ram_addr);
        end
        tick();
        req_we = 1'b0;
        #1;
        checks++;
        if (ram_we !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_write_after: we=%b rdy=%b expected 0 1", ram_we, req_ready);
        end
        req_valid = 1'b0;
        do_read(3'd5, 32'h1234_5678, "full_write_readback");
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 3'd0; req_wdata = 32'hA5A5_0001;
        #1;
        checks++;
        if (ram_we !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: we=%b rdy=%b expected 1 1", ram_we, req_ready);
        end
        tick();
        req_addr = 3'd6; req_wdata = 32'h5A5A_0002;
        #1;
        checks++;
        if (ram_we !== 1'b1 || req_ready !== 1'b1 || ram_addr !== 3'd6) begin
            errors++;
            $display("FAIL b2b_second: we=%b rdy=%b addr=%0d expected 1 1 6", ram_we, req_ready, ram_addr);
        end
        tick();
        req_valid = 1'b0;
        do_read(3'd0, 32'hA5A5_0001, "b2b_read0");
        do_read(3'd6, 32'h5A5A_0002, "b2b_read6");
    endtask

    task automatic test_partial_write();
        preload(3'd2, 32'hAABB_CCDD);
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'b0101; req_addr = 3'd2; req_wdata = 32'h1122_3344;
        #1;
        checks++;
        if (ram_we !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmw_issue: we=%b rdy=%b expected 0 1", ram_we, req_ready);
        end
        tick();
        req_valid = 1'b0; req_wdata = '0; req_addr = 3'd0;
        #1;
        checks++;
        if (req_ready !== 1'b0 || ram_we !== 1'b1 || ram_din !== 32'hAA22_CC44 || ram_addr !== 3'd2) begin
            errors++;
            $display("FAIL rmw_merge: rdy=%b we=%b din=%h addr=%0d expected 0 1 aa22cc44 2", req_ready, ram_we, ram_din, ram_addr);
        end
        tick();
        checks++;
        if (req_ready !== 1'b1 || ram_we !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmw_done: rdy=%b we=%b vld=%b expected 1 0 0", req_ready, ram_we, rsp_valid);
        end
        do_read(3'd2, 32'hAA22_CC44, "rmw_readback");
    endtask

    task automatic test_backpressure();
        logic [DWIDTH-1:0] held;
        preload(3'd7, 32'hCAFE_F00D);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd7;
        tick();
        req_valid = 1'b0;
        tick();
        held = 32'hCAFE_F00D;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 3'd7; req_wdata = 32'h0;
                #1;
            end
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0 || busy !== 1'b1 || ram_we !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle%0d: vld=%b rdata=%h rdy=%b busy=%b we=%b expected 1 %h 0 1 0",
                         c, rsp_valid, rsp_rdata, req_ready, busy, ram_we, held);
            end
            tick();
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem[7] !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL stall_release: vld=%b rdy=%b mem7=%h expected 0 1 cafef00d", rsp_valid, req_ready, mem[7]);
        end
    endtask

    task automatic test_null_write();
        preload(3'd1, 32'h0000_FFFF);
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'h0; req_addr = 3'd1; req_wdata = 32'h1234_0000;
        #1;
        checks++;
        if (ram_we !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL null_issue: we=%b rdy=%b expected 0 1", ram_we, req_ready);
        end
        tick();
        req_valid = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL null_after: vld=%b busy=%b rdy=%b expected 0 0 1", rsp_valid, busy, req_ready);
        end
        do_read(3'd1, 32'h0000_FFFF, "null_readback");
    endtask

    task automatic test_reset_in_rmw();
        preload(3'd4, 32'h5555_5555);
        req_valid = 1'b1; req_we = 1'b1; req_be = 4'b0011; req_addr = 3'd4; req_wdata = 32'h0;
        tick();
        req_valid = 1'b0;
        #1;
        checks++;
        if (fsm_state !== 2'd2) begin
            errors++;
            $display("FAIL rmw_state: st=%0d expected 2", fsm_state);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ram_we !== 1'b0 || fsm_state !== 2'd0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rmw_reset: we=%b st=%0d vld=%b busy=%b expected 0 0 0 0", ram_we, fsm_state, rsp_valid, busy);
        end
        tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (mem[4] !== 32'h5555_5555) begin
            errors++;
            $display("FAIL rmw_reset_mem: mem4=%h expected 55555555", mem[4]);
        end
        do_read(3'd4, 32'h5555_5555, "rmw_reset_readback");
    endtask

    initial begin
        test_reset();
        test_read();
        test_full_write();
        test_back_to_back();
        test_partial_write();
        test_backpressure();
        test_null_write();
        test_reset_in_rmw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
